// File: rtl/pc_stack_sequencer_if.sv
// Request/control bundle between decode, the PC stack sequencer and the
// execute-memory stage. The sequencer takes the slave side.
interface pc_stack_sequencer_if #(
  parameter int DEPTH_W = 8
);
  logic               i_call;
  logic               i_ret;
  logic               i_rti;
  logic               i_int;
  logic               o_stack_operation;
  logic               o_stack_function;
  logic               o_mem_read;
  logic               o_mem_write;
  logic               o_push_pc;
  logic               o_pop_pc;
  logic               o_branch_flags;
  logic               o_hazard_state;
  logic               o_stall;
  logic               o_int_ack;
  logic               o_int_redirect;
  logic [31:0]        o_int_vector;
  logic [DEPTH_W-1:0] o_depth;
  logic               o_stack_error;

  modport slave (
    input  i_call, i_ret, i_rti, i_int,
    output o_stack_operation, o_stack_function, o_mem_read, o_mem_write,
           o_push_pc, o_pop_pc, o_branch_flags, o_hazard_state, o_stall,
           o_int_ack, o_int_redirect, o_int_vector, o_depth, o_stack_error
  );

  modport master (
    output i_call, i_ret, i_rti, i_int,
    input  o_stack_operation, o_stack_function, o_mem_read, o_mem_write,
           o_push_pc, o_pop_pc, o_branch_flags, o_hazard_state, o_stall,
           o_int_ack, o_int_redirect, o_int_vector, o_depth, o_stack_error
  );
endinterface

// File: rtl/pc_stack_sequencer.sv
// Two-cycle PC push/pop sequencer for CALL/RET/RTI and interrupt entry;
// tracks call-frame depth, interrupt pending/in-service and stalls decode.
module pc_stack_sequencer #(
  parameter int          DEPTH_W    = 8,
  parameter logic [31:0] INT_VECTOR = 32'h0000_0000
) (
  input logic                 i_clk,
  input logic                 i_reset,
  pc_stack_sequencer_if.slave bus
);

  typedef enum logic [2:0] {IDLE, PUSH_HI, PUSH_LO, POP_LO, POP_HI} state_e;
  typedef enum logic [1:0] {K_CALL, K_INT, K_RET, K_RTI} kind_e;

  localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;

  state_e             state_q, state_d;
  kind_e              kind_q, kind_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               int_pending_q, int_pending_d;
  logic               in_isr_q, in_isr_d;

  logic stack_op, stack_fn, mem_rd, mem_wr, push_pc, pop_pc;
  logic br_flags, hazard, stall, int_ack, int_redir, stack_err, rti_done;

  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    depth_d   = depth_q;
    in_isr_d  = in_isr_q;
    stack_op  = 1'b0;
    stack_fn  = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    push_pc   = 1'b0;
    pop_pc    = 1'b0;
    br_flags  = 1'b0;
    hazard    = 1'b0;
    stall     = 1'b0;
    int_ack   = 1'b0;
    int_redir = 1'b0;
    stack_err = 1'b0;
    rti_done  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Accept is gated by reset so every output reads 0 while reset is held.
        if (!i_reset) begin
          if (bus.i_call) begin
            if (depth_q == DEPTH_MAX) begin
              stack_err = 1'b1;
            end else begin
              state_d = PUSH_HI;
              kind_d  = K_CALL;
              stall   = 1'b1;
            end
          end else if (bus.i_ret || bus.i_rti) begin
            if (depth_q == '0) begin
              stack_err = 1'b1;
            end else begin
              state_d = POP_LO;
              kind_d  = bus.i_ret ? K_RET : K_RTI;
              stall   = 1'b1;
            end
          end else if (int_pending_q) begin
            if (depth_q == DEPTH_MAX) begin
              stack_err = 1'b1;
            end else begin
              state_d  = PUSH_HI;
              kind_d   = K_INT;
              stall    = 1'b1;
              int_ack  = 1'b1;
              in_isr_d = 1'b1;
            end
          end
        end
      end
      PUSH_HI, PUSH_LO: begin
        stack_op = 1'b1;
        stack_fn = 1'b1;
        mem_wr   = 1'b1;
        push_pc  = 1'b1;
        br_flags = (kind_q == K_CALL);
        stall    = 1'b1;
        if (state_q == PUSH_HI) begin
          state_d = PUSH_LO;
        end else begin
          hazard    = 1'b1;
          int_redir = (kind_q == K_INT);
          depth_d   = depth_q + DEPTH_W'(1);
          state_d   = IDLE;
        end
      end
      POP_LO, POP_HI: begin
        stack_op = 1'b1;
        mem_rd   = 1'b1;
        pop_pc   = 1'b1;
        br_flags = (kind_q == K_RTI);
        stall    = 1'b1;
        if (state_q == POP_LO) begin
          state_d = POP_HI;
        end else begin
          hazard  = 1'b1;
          depth_d = depth_q - DEPTH_W'(1);
          state_d = IDLE;
          if (kind_q == K_RTI) begin
            rti_done = 1'b1;
            in_isr_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A request arriving on the RTI completion edge is kept, since in_isr drops there.
    int_pending_d = (int_pending_q | (bus.i_int & (~in_isr_q | rti_done))) & ~int_ack;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q       <= IDLE;
      kind_q        <= K_CALL;
      depth_q       <= '0;
      int_pending_q <= 1'b0;
      in_isr_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      kind_q        <= kind_d;
      depth_q       <= depth_d;
      int_pending_q <= int_pending_d;
      in_isr_q      <= in_isr_d;
    end
  end

  assign bus.o_stack_operation = stack_op;
  assign bus.o_stack_function  = stack_fn;
  assign bus.o_mem_read        = mem_rd;
  assign bus.o_mem_write       = mem_wr;
  assign bus.o_push_pc         = push_pc;
  assign bus.o_pop_pc          = pop_pc;
  assign bus.o_branch_flags    = br_flags;
  assign bus.o_hazard_state    = hazard;
  assign bus.o_stall           = stall;
  assign bus.o_int_ack         = int_ack;
  assign bus.o_int_redirect    = int_redir;
  assign bus.o_int_vector      = INT_VECTOR;
  assign bus.o_depth           = depth_q;
  assign bus.o_stack_error     = stack_err;

endmodule

// File: tb/tb_pc_stack_sequencer.sv
// Vector-table bench for pc_stack_sequencer with a small depth counter so the
// full-stack boundary is reachable; expected outputs flow through a scoreboard queue.
module tb_pc_stack_sequencer;

  localparam int          DW   = 2;
  localparam logic [31:0] IVEC = 32'h0000_1F00;

  // Input codes {reset, call, ret, rti, int}
  localparam logic [4:0] N  = 5'b00000;
  localparam logic [4:0] R  = 5'b10000;
  localparam logic [4:0] C  = 5'b01000;
  localparam logic [4:0] RT = 5'b00100;
  localparam logic [4:0] T  = 5'b00010;
  localparam logic [4:0] I  = 5'b00001;

  // Output word {op, func, rd, wr, push, pop, bflags, hazard, stall, ack, redir, err}
  localparam logic [11:0] O0   = 12'h000;
  localparam logic [11:0] ACC  = 12'h008;
  localparam logic [11:0] IACC = 12'h00C;
  localparam logic [11:0] ERR  = 12'h001;
  localparam logic [11:0] CH   = 12'hDA8;
  localparam logic [11:0] CL   = 12'hDB8;
  localparam logic [11:0] IH   = 12'hD88;
  localparam logic [11:0] IL   = 12'hD9A;
  localparam logic [11:0] RL   = 12'hA48;
  localparam logic [11:0] RH   = 12'hA58;
  localparam logic [11:0] TL   = 12'hA68;
  localparam logic [11:0] TH   = 12'hA78;

  typedef struct {
    logic [4:0]    in;
    logic [11:0]   outs;
    logic [DW-1:0] depth;
  } vec_t;

  typedef struct {
    int            row;
    logic [11:0]   outs;
    logic [DW-1:0] depth;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vecs[$];
  exp_t sb[$];

  pc_stack_sequencer_if #(.DEPTH_W(DW)) bus ();

  pc_stack_sequencer #(
    .DEPTH_W    (DW),
    .INT_VECTOR (IVEC)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic [4:0] in, logic [11:0] outs, int d);
    vec_t v;
    v.in    = in;
    v.outs  = outs;
    v.depth = DW'(d);
    return v;
  endfunction

  function automatic logic [11:0] actual_outs();
    return {bus.o_stack_operation, bus.o_stack_function, bus.o_mem_read,
            bus.o_mem_write, bus.o_push_pc, bus.o_pop_pc, bus.o_branch_flags,
            bus.o_hazard_state, bus.o_stall, bus.o_int_ack, bus.o_int_redirect,
            bus.o_stack_error};
  endfunction

  task automatic drive(logic [4:0] in);
    rst        = in[4];
    bus.i_call = in[3];
    bus.i_ret  = in[2];
    bus.i_rti  = in[1];
    bus.i_int  = in[0];
  endtask

  task automatic check_front();
    exp_t e;
    logic [11:0] a;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard empty: nothing expected for this sample");
      return;
    end
    e = sb.pop_front();
    a = actual_outs();
    n_checks++;
    if (a !== e.outs) begin
      n_fail++;
      $display("FAIL row%0d outs: got %b expected %b", e.row, a, e.outs);
    end
    n_checks++;
    if (bus.o_depth !== e.depth) begin
      n_fail++;
      $display("FAIL row%0d depth: got %0d expected %0d", e.row, bus.o_depth, e.depth);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   cycles;
    drive(N);

    // Reset (with a call that must be ignored), CALL, RTI, RET error
    vecs.push_back(mk(R|C, O0, 0));   vecs.push_back(mk(R,   O0, 0));
    vecs.push_back(mk(C,   ACC, 0));  vecs.push_back(mk(N,   CH, 0));
    vecs.push_back(mk(N,   CL, 0));   vecs.push_back(mk(N,   O0, 1));
    vecs.push_back(mk(T,   ACC, 1));  vecs.push_back(mk(N,   TL, 1));
    vecs.push_back(mk(N,   TH, 1));   vecs.push_back(mk(N,   O0, 0));
    vecs.push_back(mk(RT,  ERR, 0));  vecs.push_back(mk(N,   O0, 0));
    // CALL beats a simultaneous interrupt; the interrupt follows
    vecs.push_back(mk(C|I, ACC, 0));  vecs.push_back(mk(N,   CH, 0));
    vecs.push_back(mk(N,   CL, 0));   vecs.push_back(mk(N,   IACC, 1));
    vecs.push_back(mk(N,   IH, 1));   vecs.push_back(mk(N,   IL, 1));
    vecs.push_back(mk(N,   O0, 2));
    // No nesting: int held in ISR, latched on RTI completion, acked next IDLE
    vecs.push_back(mk(I,   O0, 2));   vecs.push_back(mk(I|T, ACC, 2));
    vecs.push_back(mk(I,   TL, 2));   vecs.push_back(mk(I,   TH, 2));
    vecs.push_back(mk(N,   IACC, 1)); vecs.push_back(mk(N,   IH, 1));
    vecs.push_back(mk(N,   IL, 1));   vecs.push_back(mk(N,   O0, 2));
    // Back-to-back RETs
    vecs.push_back(mk(RT,  ACC, 2));  vecs.push_back(mk(N,   RL, 2));
    vecs.push_back(mk(N,   RH, 2));   vecs.push_back(mk(RT,  ACC, 1));
    vecs.push_back(mk(N,   RL, 1));   vecs.push_back(mk(N,   RH, 1));
    vecs.push_back(mk(N,   O0, 0));
    // CALL+RET decode error: CALL served
    vecs.push_back(mk(C|RT, ACC, 0)); vecs.push_back(mk(N,   CH, 0));
    vecs.push_back(mk(N,   CL, 0));   vecs.push_back(mk(N,   O0, 1));
    // Reset during PUSH_LO
    vecs.push_back(mk(C,   ACC, 1));  vecs.push_back(mk(N,   CH, 1));
    vecs.push_back(mk(R,   CL, 1));   vecs.push_back(mk(N,   O0, 0));
    // Fill to max depth 3, then CALL and INT are rejected
    vecs.push_back(mk(C,   ACC, 0));  vecs.push_back(mk(N,   CH, 0));
    vecs.push_back(mk(N,   CL, 0));   vecs.push_back(mk(C,   ACC, 1));
    vecs.push_back(mk(N,   CH, 1));   vecs.push_back(mk(N,   CL, 1));
    vecs.push_back(mk(C,   ACC, 2));  vecs.push_back(mk(N,   CH, 2));
    vecs.push_back(mk(N,   CL, 2));   vecs.push_back(mk(N,   O0, 3));
    vecs.push_back(mk(C,   ERR, 3));  vecs.push_back(mk(I,   O0, 3));
    vecs.push_back(mk(N,   ERR, 3));  vecs.push_back(mk(N,   ERR, 3));
    vecs.push_back(mk(RT,  ACC, 3));  vecs.push_back(mk(N,   RL, 3));
    vecs.push_back(mk(N,   RH, 3));   vecs.push_back(mk(N,   IACC, 2));
    vecs.push_back(mk(N,   IH, 2));   vecs.push_back(mk(N,   IL, 2));
    vecs.push_back(mk(N,   O0, 3));

    foreach (vecs[k]) begin
      @(posedge clk);
      #1;
      drive(vecs[k].in);
      e.row   = k;
      e.outs  = vecs[k].outs;
      e.depth = vecs[k].depth;
      sb.push_back(e);
      @(negedge clk);
      check_front();
    end

    n_checks++;
    if (bus.o_int_vector !== IVEC) begin
      n_fail++;
      $display("FAIL int_vector: got %h expected %h", bus.o_int_vector, IVEC);
    end

    // RET from depth 3: stall must last exactly accept + two words, then depth 2
    @(posedge clk);
    #1;
    drive(RT);
    @(negedge clk);
    n_checks++;
    if (bus.o_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL ret_accept stall: got %b expected 1", bus.o_stall);
    end
    @(posedge clk);
    #1;
    drive(N);
    cycles = 0;
    @(negedge clk);
    while (bus.o_stall === 1'b1 && cycles < 10) begin
      cycles++;
      @(negedge clk);
    end
    n_checks++;
    if (cycles != 2) begin
      n_fail++;
      $display("FAIL ret_seq stall cycles: got %0d expected 2", cycles);
    end
    n_checks++;
    if (bus.o_depth !== DW'(2)) begin
      n_fail++;
      $display("FAIL ret_seq depth: got %0d expected 2", bus.o_depth);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_stack_sequencer.md
# pc_stack_sequencer

Control sequencer that drives the two-cycle PC push/pop protocol of the execute-memory stage. It turns single-cycle CALL/RET/RTI requests from decode, and external interrupt requests, into the ordered stack, memory and PC-select control sequence: high word then low word for push, low word then high word for pop. It also stalls fetch/decode while a sequence is in progress. It sits between the decode/ID-EX buffer and the execute-memory stage.

## Interface
Parameters:
- DEPTH_W, 8: width of the call-frame depth counter; maximum depth is 2^DEPTH_W-1.
- INT_VECTOR, 32'h0000_0000: fetch address issued on interrupt entry.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_call  in  1  decode issues CALL this cycle (push PC, keep PC[31:29]).
- i_ret  in  1  decode issues RET (pop PC).
- i_rti  in  1  decode issues RTI (pop PC, restore flags).
- i_int  in  1  external interrupt request, level, sticky-latched.
- o_stack_operation  out  1  stack pointer enable.
- o_stack_function  out  1  1 = push, 0 = pop.
- o_mem_read  out  1  data memory read.
- o_mem_write  out  1  data memory write.
- o_push_pc  out  1  write-data select = PC word.
- o_pop_pc  out  1  pop-PC sequence active.
- o_branch_flags  out  1  CALL push = 1 (PC bits kept); INT push = 0 (flags saved); RET pop = 0; RTI pop = 1 (flags restored).
- o_hazard_state  out  1  0 = first word, 1 = second word.
- o_stall  out  1  freeze fetch/decode/ID-EX.
- o_int_ack  out  1  one-cycle pulse when interrupt entry is accepted.
- o_int_redirect  out  1  one-cycle pulse; fetch loads o_int_vector.
- o_int_vector  out  32  constant INT_VECTOR.
- o_depth  out  DEPTH_W  current frame count.
- o_stack_error  out  1  one-cycle pulse on rejected request.

## Operation
- States: IDLE, PUSH_HI, PUSH_LO, POP_LO, POP_HI.
- Accept in IDLE only. Request priority: i_call > i_ret > i_rti > pending interrupt.
- Request decoding: more than one of i_call/i_ret/i_rti set in the same cycle is a decode error. The highest-priority request is served; the others are dropped.
- Interrupt latching: int_pending sets on i_int while in_isr = 0 and stays set until accepted.
- Interrupt acceptance: only in IDLE with no instruction request. Sets in_isr and pulses o_int_ack in the accept cycle.
- in_isr is cleared when an RTI sequence completes (POP_HI to IDLE). Interrupts do not nest.
- CALL or INT accepted: IDLE→PUSH_HI→PUSH_LO→IDLE; depth +1 at PUSH_LO exit.
- RET or RTI accepted: IDLE→POP_LO→POP_HI→IDLE; depth −1 at POP_HI exit.
- Push states drive: stack_operation=1, stack_function=1, mem_write=1, push_pc=1, mem_read=0.
- Pop states drive: stack_operation=1, stack_function=0, mem_read=1, pop_pc=1, mem_write=0.
- o_hazard_state: 0 in PUSH_HI/POP_LO, 1 in PUSH_LO/POP_HI. Low otherwise.
- All sequence outputs are 0 in IDLE.
- o_branch_flags is held constant for the whole sequence, per the kind latched at accept.
- INT entry: o_int_redirect pulses in PUSH_LO; o_int_vector = INT_VECTOR.
- Errors: RET/RTI with depth = 0, or CALL/INT with depth = max, are not started. They pulse o_stack_error in the request cycle and state stays IDLE. A rejected INT stays pending.
- o_stall = (state != IDLE) | (IDLE and a request is accepted this cycle).

## Timing
- Reset: state=IDLE, depth=0, int_pending=0, in_isr=0. All 1-bit outputs are 0; o_depth=0.
- Reset asserted mid-sequence aborts to IDLE on the next edge. Depth is not updated.
- Accept-to-first-word latency: 1 cycle. A sequence occupies exactly 2 cycles after accept.
- Back-to-back operation: a new request is accepted in the IDLE cycle immediately following a sequence. Minimum period is 3 cycles.
- i_call/i_ret/i_rti are sampled only in IDLE and ignored in other states. Decode holds them while o_stall=1.
- i_int in the same cycle as RTI completion is latched; in_isr is 0 from the next cycle.

## Test plan
- Reset, then i_call pulse at cycle 1 → cycle 1: o_stall=1. Cycle 2: PUSH_HI, hazard=0, mem_write=1, branch_flags=1. Cycle 3: PUSH_LO, hazard=1. Cycle 4: IDLE, o_depth=1.
- Depth=1, i_rti → cycle +1: POP_LO, mem_read=1, pop_pc=1, hazard=0, branch_flags=1. Cycle +2: hazard=1. Then o_depth=0 and in_isr cleared.
- i_ret with depth=0 → o_stack_error=1 for one cycle, no state change, o_stall=0.
- i_int with i_call in the same cycle → CALL sequence runs first. Then o_int_ack at the next IDLE, branch_flags=0, o_int_redirect in PUSH_LO, o_depth=2.
- i_int asserted while in_isr=1 → no o_int_ack until RTI completes. Ack follows in the next IDLE cycle.
- Reset asserted during PUSH_LO → next cycle IDLE, all outputs 0, o_depth unchanged (0 after reset).
